// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe board scanner: cell encoding,
// board geometry, line-to-cell table and the scan controller state type.
package ttt_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'd0;
   localparam logic [1:0] CELL_X     = 2'd1;
   localparam logic [1:0] CELL_O     = 2'd2;

   localparam int N_CELLS = 9;
   localparam int N_LINES = 8;

   // Rows, then columns, then the two diagonals; a lower index wins ties.
   localparam logic [3:0] LINE_TBL [N_LINES][3] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EVAL = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/ttt_line_check.sv
// Combinational check of one three-cell line: hit when all three cells
// hold the same mark (X or O); owner is that mark, otherwise EMPTY.
module ttt_line_check import ttt_pkg::*; #(
   parameter int CELL_W = 8
) (
   input  logic [CELL_W-1:0] a,
   input  logic [CELL_W-1:0] b,
   input  logic [CELL_W-1:0] c,
   output logic              hit,
   output logic [1:0]        owner
);

   logic mark_s;

   // Line match and owner decode.
   always_comb begin
      mark_s = (a == CELL_W'(CELL_X)) || (a == CELL_W'(CELL_O));
      hit    = mark_s && (a == b) && (a == c);
      owner  = hit ? a[1:0] : CELL_EMPTY;
   end

endmodule

// File: rtl/board_scan_ctrl.sv
// Walks the 9:1 board mux, snapshots every cell and reports winner/draw/invalid.
// Optional BOARD_SCAN_LINE_REPORT_EN adds win_line_o, the winning line index.
module board_scan_ctrl #(
   parameter int CELL_W  = 8,
   parameter int N_CELLS = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [CELL_W-1:0] mux_data_i,
`ifdef BOARD_SCAN_LINE_REPORT_EN
   output logic [2:0]        win_line_o,
`endif
   output logic [3:0]        sel_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [1:0]        winner_o,
   output logic              draw_o,
   output logic              invalid_o
);
   import ttt_pkg::*;

   state_t            state_r;
   logic [CELL_W-1:0] cell_r [N_CELLS];

   logic [N_LINES-1:0] hit_s;
   logic [1:0]         owner_s [N_LINES];
   logic [1:0]         win_s;
   logic               full_s;
   logic               draw_s;
   logic               invalid_s;

   for (genvar g = 0; g < N_LINES; g++) begin : g_line
      ttt_line_check #(.CELL_W(CELL_W)) u_chk (
         .a     (cell_r[LINE_TBL[g][0]]),
         .b     (cell_r[LINE_TBL[g][1]]),
         .c     (cell_r[LINE_TBL[g][2]]),
         .hit   (hit_s[g]),
         .owner (owner_s[g])
      );
   end

   // Board evaluation over the snapshot; the descending loop lets the lowest winning line prevail.
   always_comb begin
      win_s     = 2'd0;
      full_s    = 1'b1;
      invalid_s = 1'b0;
      for (int l = N_LINES - 1; l >= 0; l--) begin
         win_s = hit_s[l] ? owner_s[l] : win_s;
      end
      for (int c = 0; c < N_CELLS; c++) begin
         full_s    = full_s & ((cell_r[c] == CELL_W'(CELL_X)) || (cell_r[c] == CELL_W'(CELL_O)));
         invalid_s = invalid_s | (cell_r[c] > CELL_W'(CELL_O));
      end
      draw_s = full_s && (win_s == 2'd0);
   end

`ifdef BOARD_SCAN_LINE_REPORT_EN
   logic [2:0] line_s;

   // Index of the lowest winning line, zero when nobody wins.
   always_comb begin
      line_s = 3'd0;
      for (int l = N_LINES - 1; l >= 0; l--) begin
         line_s = hit_s[l] ? 3'(l) : line_s;
      end
   end
`endif

   // Scan sequencer: select stepping, snapshot capture and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         sel_o     <= 4'd0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         winner_o  <= 2'd0;
         draw_o    <= 1'b0;
         invalid_o <= 1'b0;
`ifdef BOARD_SCAN_LINE_REPORT_EN
         win_line_o <= 3'd0;
`endif
         for (int i = 0; i < N_CELLS; i++) begin
            cell_r[i] <= '0;
         end
      end else begin
         case (state_r)
            IDLE: begin
               sel_o  <= 4'd0;
               done_o <= 1'b0;
               if (start_i) begin
                  state_r   <= SCAN;
                  busy_o    <= 1'b1;
                  winner_o  <= 2'd0;
                  draw_o    <= 1'b0;
                  invalid_o <= 1'b0;
`ifdef BOARD_SCAN_LINE_REPORT_EN
                  win_line_o <= 3'd0;
`endif
               end
            end
            SCAN: begin
               for (int i = 0; i < N_CELLS; i++) begin
                  if (sel_o == 4'(i)) begin
                     cell_r[i] <= mux_data_i;
                  end
               end
               if (sel_o == 4'(N_CELLS - 1)) begin
                  state_r <= EVAL;
                  sel_o   <= 4'd0;
               end else begin
                  sel_o <= sel_o + 4'd1;
               end
            end
            EVAL: begin
               state_r   <= DONE;
               busy_o    <= 1'b0;
               done_o    <= 1'b1;
               winner_o  <= win_s;
               draw_o    <= draw_s;
               invalid_o <= invalid_s;
`ifdef BOARD_SCAN_LINE_REPORT_EN
               win_line_o <= line_s;
`endif
            end
            DONE: begin
               state_r <= IDLE;
               done_o  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               sel_o   <= 4'd0;
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_board_scan_ctrl.sv
// Directed bench for board_scan_ctrl: a behavioural board drives the mux input,
// expected results go into a scoreboard queue at start and are checked at done_o.
module tb_board_scan_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start_i;
   logic [7:0] mux_data_i;
   logic [3:0] sel_o;
   logic       busy_o;
   logic       done_o;
   logic [1:0] winner_o;
   logic       draw_o;
   logic       invalid_o;
`ifdef BOARD_SCAN_LINE_REPORT_EN
   logic [2:0] win_line_o;
`endif

   typedef struct packed {
      logic [1:0] w;
      logic       d;
      logic       i;
      logic [2:0] l;
   } exp_t;

   exp_t        sb[$];
   logic [71:0] board_v;
   int          n_pass;
   int          n_total;

   board_scan_ctrl #(.CELL_W(8), .N_CELLS(9)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .mux_data_i (mux_data_i),
`ifdef BOARD_SCAN_LINE_REPORT_EN
      .win_line_o (win_line_o),
`endif
      .sel_o      (sel_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .winner_o   (winner_o),
      .draw_o     (draw_o),
      .invalid_o  (invalid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural 9:1 mux in front of the DUT.
   always_comb begin
      mux_data_i = 8'd0;
      if (sel_o < 4'd9) mux_data_i = board_v[int'(sel_o) * 8 +: 8];
   end

   function automatic logic [71:0] brd(input logic [7:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
      return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic check_results(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_winner"},  32'(winner_o),  32'(e.w));
         check({tag, "_draw"},    32'(draw_o),    32'(e.d));
         check({tag, "_invalid"}, 32'(invalid_o), 32'(e.i));
`ifdef BOARD_SCAN_LINE_REPORT_EN
         check({tag, "_line"},    32'(win_line_o), 32'(e.l));
`endif
      end
   endtask

   // Starts a scan at a negedge; the first posedge after that samples start_i and is
   // counted as edge 1, so done_o must be seen after edge 11.
   // inject_at > 0 pulses start_i again at that edge count; hold keeps start_i high.
   task automatic run_scan(input string tag, input logic [71:0] b, input exp_t e,
                           input bit chk_sel, input int inject_at, input bit hold);
      int n;
      bit seen;
      board_v = b;
      sb.push_back(e);
      start_i = 1'b1;
      n = 0;
      seen = 1'b0;
      while (n < 30 && !seen) begin
         @(negedge clk);
         n++;
         start_i = hold || (inject_at > 0 && n == inject_at);
         if (chk_sel && n <= 9) begin
            check({tag, "_sel"},  32'(sel_o),  32'(n - 1));
            check({tag, "_busy"}, 32'(busy_o), 32'd1);
         end
         if (done_o) seen = 1'b1;
      end
      check({tag, "_done_edge"}, 32'(n), 32'd11);
      if (seen) check_results(tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
      check({tag, "_idle_busy"},  32'(busy_o), 32'd0);
   endtask

   initial begin
      int dones;
      n_pass  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      start_i = 1'b0;
      board_v = '0;

      repeat (2) @(negedge clk);
      check("rst_sel",     32'(sel_o),     32'd0);
      check("rst_busy",    32'(busy_o),    32'd0);
      check("rst_done",    32'(done_o),    32'd0);
      check("rst_winner",  32'(winner_o),  32'd0);
      check("rst_draw",    32'(draw_o),    32'd0);
      check("rst_invalid", 32'(invalid_o), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Top row of X.
      run_scan("row0", brd(8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0),
               '{w: 2'd1, d: 1'b0, i: 1'b0, l: 3'd0}, 1'b1, 0, 1'b0);
      repeat (5) @(negedge clk);
      check("hold_winner", 32'(winner_o), 32'd1);

      // Anti-diagonal of O with two stray X.
      run_scan("diag", brd(8'd1, 8'd1, 8'd2, 8'd0, 8'd2, 8'd0, 8'd2, 8'd0, 8'd0),
               '{w: 2'd2, d: 1'b0, i: 1'b0, l: 3'd7}, 1'b0, 0, 1'b0);

      // Full board, no line: X,O,X / X,O,O / O,X,X.
      run_scan("draw", brd(8'd1, 8'd2, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1),
               '{w: 2'd0, d: 1'b1, i: 1'b0, l: 3'd0}, 1'b0, 0, 1'b0);

      run_scan("empty", '0, '{w: 2'd0, d: 1'b0, i: 1'b0, l: 3'd0}, 1'b0, 0, 1'b0);

      run_scan("inval", brd(8'd0, 8'd0, 8'd0, 8'd0, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0),
               '{w: 2'd0, d: 1'b0, i: 1'b1, l: 3'd0}, 1'b0, 0, 1'b0);

      // Middle column of X beats the lower-priority diagonal of X.
      run_scan("prio", brd(8'd0, 8'd1, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 8'd0),
               '{w: 2'd1, d: 1'b0, i: 1'b0, l: 3'd4}, 1'b0, 0, 1'b0);

      // Extra start in the middle of the scan must be ignored.
      run_scan("ign", brd(8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0),
               '{w: 2'd1, d: 1'b0, i: 1'b0, l: 3'd0}, 1'b1, 4, 1'b0);
      dones = 0;
      repeat (15) begin
         @(negedge clk);
         if (done_o) dones++;
      end
      check("ign_no_extra_done", 32'(dones), 32'd0);

      // Start held high: two scans back to back, 12 cycles apart.
      run_scan("b2b_a", brd(8'd2, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0),
               '{w: 2'd2, d: 1'b0, i: 1'b0, l: 3'd3}, 1'b0, 0, 1'b1);
      run_scan("b2b_b", brd(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1),
               '{w: 2'd1, d: 1'b0, i: 1'b0, l: 3'd2}, 1'b0, 0, 1'b0);
      start_i = 1'b0;
      @(negedge clk);

      // Reset in the middle of a scan.
      board_v = brd(8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_sel_before", 32'(sel_o), 32'd4);
      rst_n = 1'b0;
      #1;
      check("mid_busy",   32'(busy_o),   32'd0);
      check("mid_sel",    32'(sel_o),    32'd0);
      check("mid_winner", 32'(winner_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (15) begin
         @(negedge clk);
         if (done_o || busy_o) dones++;
      end
      check("mid_no_done", 32'(dones), 32'd0);
      run_scan("post_rst", brd(8'd1, 8'd1, 8'd2, 8'd0, 8'd2, 8'd0, 8'd2, 8'd0, 8'd0),
               '{w: 2'd2, d: 1'b0, i: 1'b0, l: 3'd7}, 1'b1, 0, 1'b0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
